// File: rtl/picture_mode_ctrl.sv
`default_nettype none
// ============================================================================
// picture_mode_ctrl : frame-synchronous test-pattern mode sequencer
//                     (manual button stepping or automatic dwell cycling)
// Revision 1.0
// ============================================================================
module picture_mode_ctrl #(
  parameter int MaxModes    = 8,
  parameter int ModeWidth   = $clog2(MaxModes),
  parameter int DwellFrames = 60,
  parameter int InitMode    = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 enable_i,
  input  logic                 frame_end_i,
  input  logic                 auto_en_i,
  input  logic                 btn_next_i,
  input  logic                 btn_prev_i,
  output logic [ModeWidth-1:0] mode_o,
  output logic                 mode_change_o,
  output logic                 pending_o
);

  localparam int                   CntWidth  = $clog2(DwellFrames + 1);
  localparam logic [CntWidth-1:0]  DwellLast = CntWidth'(DwellFrames - 1);
  localparam logic [ModeWidth-1:0] ModeLast  = ModeWidth'(MaxModes - 1);
  localparam logic [ModeWidth-1:0] ModeInit  = ModeWidth'(InitMode);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MANUAL = 2'd1,
    AUTO   = 2'd2
  } state_t;

  state_t                state;
  state_t                next_state;
  logic                  pend_next;
  logic [CntWidth-1:0]   dwell_cnt;
  logic [CntWidth-1:0]   dwell_base;
  logic                  req_valid;
  logic                  req_next;
  logic                  apply_valid;
  logic                  apply_next;
  logic [ModeWidth-1:0]  mode_inc;
  logic [ModeWidth-1:0]  mode_dec;

  // A fresh request in this cycle beats an older latched one.
  always_comb begin
    next_state = IDLE;
    if (enable_i) begin
      next_state = auto_en_i ? AUTO : MANUAL;
    end
    req_valid   = btn_next_i ^ btn_prev_i;
    req_next    = btn_next_i;
    apply_valid = req_valid | pending_o;
    apply_next  = req_valid ? req_next : pend_next;
    dwell_base  = (state == AUTO) ? dwell_cnt : '0;
    mode_inc    = (mode_o == ModeLast) ? '0 : mode_o + ModeWidth'(1);
    mode_dec    = (mode_o == '0) ? ModeLast : mode_o - ModeWidth'(1);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state         <= IDLE;
      mode_o        <= ModeInit;
      mode_change_o <= 1'b0;
      pending_o     <= 1'b0;
      pend_next     <= 1'b0;
      dwell_cnt     <= '0;
    end else begin
      state         <= next_state;
      mode_change_o <= 1'b0;
      case (next_state)
        IDLE: begin
          pending_o <= 1'b0;
          pend_next <= 1'b0;
          dwell_cnt <= '0;
        end
        default: begin
          dwell_cnt <= '0;
          if (frame_end_i) begin
            if (apply_valid) begin
              mode_o        <= apply_next ? mode_inc : mode_dec;
              mode_change_o <= 1'b1;
              pending_o     <= 1'b0;
            end else if (next_state == AUTO) begin
              if (dwell_base == DwellLast) begin
                mode_o        <= mode_inc;
                mode_change_o <= 1'b1;
              end else begin
                dwell_cnt <= dwell_base + CntWidth'(1);
              end
            end
          end else begin
            if (req_valid) begin
              pending_o <= 1'b1;
              pend_next <= req_next;
            end
            if (next_state == AUTO) begin
              dwell_cnt <= dwell_base;
            end
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_picture_mode_ctrl.sv
`default_nettype none
// ============================================================================
// tb_picture_mode_ctrl : directed + randomized bench with a behavioural model
// Revision 1.0
// ============================================================================
module tb_picture_mode_ctrl;

  localparam int MA = 8, DA = 3, IA = 2;
  localparam int MB = 5, DB = 1, IB = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0, frame_end = 1'b0, auto_en = 1'b0, btn_next = 1'b0, btn_prev = 1'b0;
  logic [2:0] mode_a, mode_b;
  logic chg_a, chg_b, pend_a, pend_b;

  always #5 clk = ~clk;

  picture_mode_ctrl #(.MaxModes(MA), .DwellFrames(DA), .InitMode(IA)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .frame_end_i(frame_end),
    .auto_en_i(auto_en), .btn_next_i(btn_next), .btn_prev_i(btn_prev),
    .mode_o(mode_a), .mode_change_o(chg_a), .pending_o(pend_a));

  picture_mode_ctrl #(.MaxModes(MB), .DwellFrames(DB), .InitMode(IB)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .frame_end_i(frame_end),
    .auto_en_i(auto_en), .btn_next_i(btn_next), .btn_prev_i(btn_prev),
    .mode_o(mode_b), .mode_change_o(chg_b), .pending_o(pend_b));

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: pending is a signed step (+1/-1/0), dwell counts frames.
  int m_mode[2], m_pend[2], m_dwell[2], m_chg[2];
  bit m_valid = 1'b0;

  function automatic int nmodes(input int i);
    return (i == 0) ? MA : MB;
  endfunction
  function automatic int ndwell(input int i);
    return (i == 0) ? DA : DB;
  endfunction
  function automatic int ninit(input int i);
    return (i == 0) ? IA : IB;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int req, step;
      req = 0;
      if (btn_next != btn_prev) req = btn_next ? 1 : -1;
      m_chg[i] = 0;
      if (!rst_n) begin
        m_mode[i] = ninit(i); m_pend[i] = 0; m_dwell[i] = 0; m_valid = 1'b1;
      end else if (!enable) begin
        m_pend[i] = 0; m_dwell[i] = 0;
      end else begin
        if (frame_end) begin
          step = (req != 0) ? req : m_pend[i];
          if (step != 0) begin
            m_mode[i] = (m_mode[i] + step + nmodes(i)) % nmodes(i);
            m_pend[i] = 0; m_dwell[i] = 0; m_chg[i] = 1;
          end else if (auto_en) begin
            if (m_dwell[i] == ndwell(i) - 1) begin
              m_mode[i] = (m_mode[i] + 1) % nmodes(i);
              m_dwell[i] = 0; m_chg[i] = 1;
            end else begin
              m_dwell[i]++;
            end
          end
        end else if (req != 0) begin
          m_pend[i] = req;
        end
        if (!auto_en) m_dwell[i] = 0;
      end
    end
  end

  int chg_cnt_a = 0;

  always @(negedge clk) begin
    if (chg_a) chg_cnt_a++;
    if (m_valid) begin
      chk("mode_a", int'(mode_a), m_mode[0]);
      chk("chg_a", int'(chg_a), m_chg[0]);
      chk("pend_a", int'(pend_a), (m_pend[0] != 0) ? 1 : 0);
      chk("mode_b", int'(mode_b), m_mode[1]);
      chk("chg_b", int'(chg_b), m_chg[1]);
      chk("pend_b", int'(pend_b), (m_pend[1] != 0) ? 1 : 0);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic fe, input logic nx, input logic pv);
    frame_end = fe; btn_next = nx; btn_prev = pv;
    cyc();
    frame_end = 1'b0; btn_next = 1'b0; btn_prev = 1'b0;
  endtask

  initial begin
    int e39[6];
    e39 = '{2, 2, 3, 3, 3, 4};

    cyc(); cyc();
    chk("reset_mode", int'(mode_a), IA);
    chk("reset_pend", int'(pend_a), 0);
    chk("reset_chg", int'(chg_a), 0);
    chk("reset_mode_b", int'(mode_b), IB);
    rst_n = 1'b1; enable = 1'b1; auto_en = 1'b0;
    cyc();

    // 2 -> 1 -> 0 -> 7 with requests coinciding with frame ends
    repeat (3) drive(1'b1, 1'b0, 1'b1);
    chk("wrap_prev_7", int'(mode_a), 7);

    // next latched, frame end 20 cycles later
    drive(1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 19; k++) begin
      chk("pending_hold", int'(pend_a), 1);
      cyc();
    end
    drive(1'b1, 1'b0, 1'b0);
    chk("wrap_next_0", int'(mode_a), 0);
    chk("chg_pulse", int'(chg_a), 1);
    chk("pend_cleared", int'(pend_a), 0);
    cyc();
    chk("chg_one_cycle", int'(chg_a), 0);

    // last request wins, one change pulse
    chg_cnt_a = 0;
    drive(1'b0, 1'b0, 1'b1);
    cyc();
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b0);
    chk("last_wins", int'(mode_a), 7);
    cyc(); cyc();
    chk("one_pulse", chg_cnt_a, 1);

    // 7 -> 0 -> 1 -> 2, then auto dwell of 3
    repeat (3) drive(1'b1, 1'b1, 1'b0);
    chk("setup_2", int'(mode_a), 2);
    auto_en = 1'b1; cyc(); cyc();
    for (int p = 0; p < 6; p++) begin
      drive(1'b1, 1'b0, 1'b0);
      chk("auto_dwell", int'(mode_a), e39[p]);
      cyc(); cyc();
    end

    // manual request coinciding with dwell expiry
    auto_en = 1'b0; cyc();
    repeat (2) drive(1'b1, 1'b0, 1'b1);
    chk("setup_2b", int'(mode_a), 2);
    auto_en = 1'b1; cyc();
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    chk("before_coincide", int'(mode_a), 2);
    drive(1'b1, 1'b1, 1'b0);
    chk("no_double_step", int'(mode_a), 3);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    chk("dwell_restart", int'(mode_a), 3);
    drive(1'b1, 1'b0, 1'b0);
    chk("dwell_after_restart", int'(mode_a), 4);

    // simultaneous buttons keep pending; disable clears it
    auto_en = 1'b0; cyc();
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b1);
    chk("both_keep_pend", int'(pend_a), 1);
    enable = 1'b0;
    drive(1'b1, 1'b0, 1'b0);
    chk("idle_mode", int'(mode_a), 4);
    chk("idle_chg", int'(chg_a), 0);
    chk("idle_pend", int'(pend_a), 0);
    enable = 1'b1; cyc();
    drive(1'b1, 1'b0, 1'b0);
    chk("idle_dropped_req", int'(mode_a), 4);

    // reset discards pending and partial dwell
    auto_en = 1'b1; cyc();
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0);
    chk("pend_before_rst", int'(pend_a), 1);
    rst_n = 1'b0; cyc(); rst_n = 1'b1;
    chk("rst_mode", int'(mode_a), IA);
    chk("rst_pend", int'(pend_a), 0);
    cyc();
    chk("rst_exit_chg", int'(chg_a), 0);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    chk("rst_dwell_2", int'(mode_a), IA);
    drive(1'b1, 1'b0, 1'b0);
    chk("rst_dwell_3", int'(mode_a), IA + 1);

    // randomized phase, checked every cycle by the model
    for (int n = 0; n < 5000; n++) begin
      rst_n     = ($urandom % 300) != 0;
      enable    = ($urandom % 16) != 0;
      if (($urandom % 48) == 0) auto_en = ~auto_en;
      frame_end = ($urandom % 6) == 0;
      btn_next  = ($urandom % 7) == 0;
      btn_prev  = ($urandom % 7) == 0;
      cyc();
    end
    frame_end = 1'b0; btn_next = 1'b0; btn_prev = 1'b0;
    cyc(); cyc();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/picture_mode_ctrl.md
PICTURE_MODE_CTRL -- requirements
Module: picture_mode_ctrl

Interface
REQ-001 Parameter MaxModes, default 8, number of test-pattern modes sequenced.
REQ-002 Parameter ModeWidth, default $clog2(MaxModes), width of mode_o.
REQ-003 Parameter DwellFrames, default 60, frames each mode is shown in auto mode (legal range >= 1).
REQ-004 Parameter InitMode, default 0, mode_o value after reset (legal range < MaxModes).
REQ-005 clk_i  input  1  pixel clock; the single clock of the block.
REQ-006 rst_ni  input  1  reset, synchronous, active-low.
REQ-007 enable_i  input  1  block enable; low freezes sequencing.
REQ-008 frame_end_i  input  1  one-cycle pulse on the last visible pixel of each frame.
REQ-009 auto_en_i  input  1  level; high selects automatic cycling, low selects manual.
REQ-010 btn_next_i  input  1  one-cycle request pulse, already debounced: advance to next mode.
REQ-011 btn_prev_i  input  1  one-cycle request pulse, already debounced: step to previous mode.
REQ-012 mode_o  output  ModeWidth  registered mode selection driving the pattern generator.
REQ-013 mode_change_o  output  1  one-cycle pulse, high in the first cycle a new mode_o value is visible.
REQ-014 pending_o  output  1  high while a manual request is latched but not yet applied.

Function
REQ-015 The block SHALL implement the states IDLE, MANUAL and AUTO.
REQ-016 Transitions SHALL be evaluated every cycle: enable_i=0 -> IDLE; enable_i=1 and auto_en_i=0 -> MANUAL; enable_i=1 and auto_en_i=1 -> AUTO.
REQ-017 In IDLE, mode_o SHALL hold its value, mode_change_o SHALL be 0, the pending request SHALL be cleared, and the dwell counter SHALL be cleared.
REQ-018 In MANUAL and AUTO, a btn_next_i or btn_prev_i pulse SHALL be latched as the pending request (direction next or prev), and pending_o SHALL be set the following cycle.
REQ-019 A newer request SHALL overwrite an older pending one; the last request before frame_end_i wins.
REQ-020 If btn_next_i and btn_prev_i are both high in the same cycle, that cycle's request SHALL be ignored, and any existing pending request SHALL be kept.
REQ-021 A request arriving in the same cycle as frame_end_i SHALL be applied at that frame end, taking precedence over a pending request.
REQ-022 Mode changes SHALL occur only on frame_end_i.
REQ-023 On a frame end where a change applies, mode_o SHALL update on the next clock edge (latency 1 cycle), and mode_change_o SHALL be high in that same cycle.
REQ-024 Applying a manual request SHALL clear the pending request and pending_o.
REQ-025 Next SHALL wrap MaxModes-1 -> 0; prev SHALL wrap 0 -> MaxModes-1.
REQ-026 Mode arithmetic SHALL stay modulo MaxModes even when MaxModes is not a power of two.
REQ-027 In AUTO, the dwell counter SHALL increment on each frame_end_i.
REQ-028 In AUTO, when frame_end_i occurs with the counter equal to DwellFrames-1, mode_o SHALL advance by one (with wrap) and the counter SHALL return to 0.
REQ-029 If a manual request and dwell expiry coincide on one frame end, only the manual request SHALL be applied (no double step), and the dwell counter SHALL return to 0.
REQ-030 Any manual request applied in AUTO SHALL restart the dwell counter at 0.
REQ-031 Entering AUTO from MANUAL or IDLE SHALL clear the dwell counter.
REQ-032 The dwell counter SHALL be $clog2(DwellFrames+1) bits wide and SHALL never exceed DwellFrames-1.
REQ-033 In MANUAL, the dwell counter SHALL hold at 0.
REQ-034 A frame_end_i pulse with no applicable change SHALL leave mode_o unchanged and mode_change_o low.

Reset
REQ-035 While rst_ni=0 at a clock edge: state=IDLE, mode_o=InitMode, mode_change_o=0, pending_o=0, pending request cleared, dwell counter=0.
REQ-036 Reset mid-operation SHALL discard pending requests and partial dwell counts, with no mode_change_o pulse on reset exit.

Verification
REQ-037 MANUAL, mode_o=7, btn_next_i pulse, frame_end_i 20 cycles later -> pending_o high for those cycles; mode_o=0 one cycle after frame_end_i with mode_change_o pulse.
REQ-038 MANUAL, mode_o=0, btn_prev_i then btn_next_i then btn_prev_i before frame_end_i -> mode_o=7 after the frame end; exactly one mode_change_o pulse.
REQ-039 AUTO, DwellFrames=3, mode_o=2, 6 frame_end_i pulses -> mode_o=3 after pulse 3, mode_o=4 after pulse 6; no other changes.
REQ-040 AUTO, DwellFrames=3, btn_next_i in the same cycle as the 3rd frame_end_i, mode_o=2 -> mode_o=3 (not 4); the next auto step occurs 3 frames later.
REQ-041 btn_next_i and btn_prev_i together, then enable_i=0 across frame_end_i -> mode_o unchanged; pending_o=0; no mode_change_o pulse.
REQ-042 Pending request plus dwell count 2, then rst_ni low 1 cycle -> mode_o=InitMode; pending_o=0; in AUTO, the first advance comes DwellFrames frames after release.
